// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory-stage access controller: FSM encodings
// and default sizing.
package mem_access_ctrl_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF   = 4;
    localparam int STATE_W     = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/mem_access_ctrl_register_16b.sv
// Enabled data register with async active-low clear; parks load data while
// the downstream pipeline is frozen.
module register_16b #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = en ? d : q_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= '0;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: issues one req/done transaction per
// MEM instruction, stalls the pipe while it is in flight, flags faults.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_MEM,
    input  logic              memRead_MEM,
    input  logic              memWrite_MEM,
    input  logic [DATA_W-1:0] addr_MEM,
    input  logic [DATA_W-1:0] wdata_MEM,
    input  logic              HALT_MEM,
    input  logic              pipe_en,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] data_MEM,
    output logic              stall_MEM,
    output logic              err_MEM
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halted_q, halted_d;
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic               access;
    logic               hold_en;
    logic [DATA_W-1:0]  hold_data;
    logic [DATA_W-1:0]  rd_result;
    logic               stall_c;
    logic               err_c;
    logic [DATA_W-1:0]  data_c;

    assign access    = valid_MEM & (memRead_MEM | memWrite_MEM) & ~halted_q;
    // Stores complete with no data for the writeback stage.
    assign rd_result = wr_q ? '0 : mem_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall_c = 1'b0;
        err_c   = 1'b0;
        data_c  = '0;
        hold_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (addr_MEM[0]) begin
                        err_c = 1'b1;
                    end else begin
                        wr_d    = memWrite_MEM;
                        addr_d  = addr_MEM;
                        wdata_d = wdata_MEM;
                        cnt_d   = '0;
                        stall_c = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A completion that lands on the last allowed cycle beats the timeout.
                if (mem_done) begin
                    data_c = rd_result;
                    if (pipe_en) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_en = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    stall_c = 1'b1;
                end
            end
            ST_HOLD: begin
                data_c = hold_data;
                if (pipe_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        halted_d = halted_q | (valid_MEM & HALT_MEM & pipe_en & ~stall_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    register_16b #(.W(DATA_W)) u_hold (
        .clk (clk),
        .rst (rst),
        .en  (hold_en),
        .d   (rd_result),
        .q   (hold_data)
    );

    // Combinational outputs are gated so an asserted reset silences them at once.
    assign mem_req   = (state_q == ST_WAIT);
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stall_MEM = stall_c & rst;
    assign err_MEM   = err_c & rst;
    assign data_MEM  = rst ? data_c : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus random
// transactions against a per-transaction timing model.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_MEM, memRead_MEM, memWrite_MEM, HALT_MEM, pipe_en;
    logic [15:0] addr_MEM, wdata_MEM;
    logic        mem_req, mem_wr, mem_done, stall_MEM, err_MEM;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, data_MEM;

    int n_cmp = 0;
    int n_bad = 0;
    logic halted_m = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(16), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_MEM    (valid_MEM),
        .memRead_MEM  (memRead_MEM),
        .memWrite_MEM (memWrite_MEM),
        .addr_MEM     (addr_MEM),
        .wdata_MEM    (wdata_MEM),
        .HALT_MEM     (HALT_MEM),
        .pipe_en      (pipe_en),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .data_MEM     (data_MEM),
        .stall_MEM    (stall_MEM),
        .err_MEM      (err_MEM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".req"},   {31'd0, mem_req},   0);
        chk({tag, ".stall"}, {31'd0, stall_MEM}, 0);
        chk({tag, ".err"},   {31'd0, err_MEM},   0);
        chk({tag, ".data"},  {16'd0, data_MEM},  0);
    endtask

    // One MEM instruction. done_at: WAIT cycle (1-based) carrying mem_done,
    // 0 = memory never answers. pe_low: cycles pipe_en is low from the done cycle.
    task automatic xact(input string tag, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input int done_at, input logic [15:0] rdv, input int pe_low);
        logic [15:0] exp_data;
        logic        got_done;
        exp_data = wr ? 16'h0 : rdv;
        got_done = 1'b0;
        @(negedge clk);
        valid_MEM = 1'b1; memRead_MEM = rd; memWrite_MEM = wr; HALT_MEM = 1'b0;
        addr_MEM = addr; wdata_MEM = wd; mem_done = 1'b0; pipe_en = 1'b1;
        #1;
        if (!(rd | wr) || halted_m) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, ".noacc.stall"}, {31'd0, stall_MEM}, 0);
                chk({tag, ".noacc.req"},   {31'd0, mem_req},   0);
                @(negedge clk); #1;
            end
        end else if (addr[0]) begin
            chk({tag, ".mis.err"},   {31'd0, err_MEM},   1);
            chk({tag, ".mis.stall"}, {31'd0, stall_MEM}, 0);
            chk({tag, ".mis.req"},   {31'd0, mem_req},   0);
        end else begin
            chk({tag, ".issue.stall"}, {31'd0, stall_MEM}, 1);
            chk({tag, ".issue.req"},   {31'd0, mem_req},   0);
            for (int k = 1; k <= TIMEOUT; k++) begin
                @(negedge clk);
                mem_done  = (k == done_at);
                mem_rdata = mem_done ? rdv : 16'($urandom);
                pipe_en   = mem_done ? (pe_low == 0) : 1'($urandom);
                #1;
                chk({tag, ".wait.req"},   {31'd0, mem_req},   1);
                chk({tag, ".wait.wr"},    {31'd0, mem_wr},    {31'd0, wr});
                chk({tag, ".wait.addr"},  {16'd0, mem_addr},  {16'd0, addr});
                chk({tag, ".wait.wdata"}, {16'd0, mem_wdata}, {16'd0, wd});
                if (mem_done) begin
                    got_done = 1'b1;
                    chk({tag, ".done.stall"}, {31'd0, stall_MEM}, 0);
                    chk({tag, ".done.err"},   {31'd0, err_MEM},   0);
                    if (pe_low == 0) chk({tag, ".done.data"}, {16'd0, data_MEM}, {16'd0, exp_data});
                    break;
                end else if (k == TIMEOUT) begin
                    chk({tag, ".tmo.err"},   {31'd0, err_MEM},   1);
                    chk({tag, ".tmo.stall"}, {31'd0, stall_MEM}, 0);
                    chk({tag, ".tmo.data"},  {16'd0, data_MEM},  0);
                end else begin
                    chk({tag, ".wait.stall"}, {31'd0, stall_MEM}, 1);
                    chk({tag, ".wait.err"},   {31'd0, err_MEM},   0);
                end
            end
            if (got_done) begin
                for (int j = 1; j <= pe_low; j++) begin
                    @(negedge clk);
                    mem_done = 1'b0; mem_rdata = 16'($urandom); pipe_en = (j == pe_low);
                    #1;
                    chk({tag, ".hold.req"},   {31'd0, mem_req},   0);
                    chk({tag, ".hold.stall"}, {31'd0, stall_MEM}, 0);
                    chk({tag, ".hold.data"},  {16'd0, data_MEM},  {16'd0, exp_data});
                end
            end
        end
        @(negedge clk);
        valid_MEM = 1'b0; memRead_MEM = 1'b0; memWrite_MEM = 1'b0;
        mem_done = 1'b0; pipe_en = 1'b1;
        #1;
        chk_idle({tag, ".after"});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        valid_MEM = 1'b0; memRead_MEM = 1'b0; memWrite_MEM = 1'b0; HALT_MEM = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        halted_m = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        valid_MEM = 1'b0; memRead_MEM = 1'b0; memWrite_MEM = 1'b0; HALT_MEM = 1'b0;
        pipe_en = 1'b1; addr_MEM = '0; wdata_MEM = '0; mem_done = 1'b0; mem_rdata = '0;
        #2;
        chk_idle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        xact("load",     1'b1, 1'b0, 16'h0010, 16'h0000, 3,  16'hBEEF, 0);
        xact("store",    1'b0, 1'b1, 16'h0020, 16'h1234, 2,  16'h7777, 0);
        xact("misalign", 1'b1, 1'b0, 16'h0011, 16'h0000, 1,  16'h0000, 0);
        xact("timeout",  1'b1, 1'b0, 16'h0050, 16'h0000, 0,  16'h0000, 0);
        xact("hold",     1'b1, 1'b0, 16'h0060, 16'h0000, 1,  16'hA5A5, 2);
        xact("lastdone", 1'b1, 1'b0, 16'h0070, 16'h0000, 15, 16'h3C3C, 0);
        xact("rdwr",     1'b1, 1'b1, 16'h0080, 16'h5555, 1,  16'h9999, 0);
        xact("noop",     1'b0, 1'b0, 16'h0090, 16'h0000, 1,  16'h0000, 0);

        for (int t = 0; t < 40; t++) begin
            logic        r_rd, r_wr;
            logic [15:0] r_addr;
            int          r_done, r_pe;
            r_rd   = 1'($urandom);
            r_wr   = 1'($urandom);
            r_addr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) r_addr[0] = 1'b0;
            r_done = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, TIMEOUT);
            r_pe   = r_wr ? 0 : $urandom_range(0, 3);
            xact("rand", r_rd, r_wr, r_addr, 16'($urandom), r_done, 16'($urandom), r_pe);
        end

        @(negedge clk);
        valid_MEM = 1'b1; HALT_MEM = 1'b1; pipe_en = 1'b1; #1;
        chk("halt.stall", {31'd0, stall_MEM}, 0);
        halted_m = 1'b1;
        @(negedge clk);
        valid_MEM = 1'b0; HALT_MEM = 1'b0;
        xact("halted", 1'b1, 1'b0, 16'h0030, 16'h0000, 1, 16'h1111, 0);

        pulse_reset();
        @(negedge clk);
        valid_MEM = 1'b1; memRead_MEM = 1'b1; addr_MEM = 16'h0040; pipe_en = 1'b1; #1;
        chk("rstmid.issue", {31'd0, stall_MEM}, 1);
        repeat (2) begin
            @(negedge clk); mem_done = 1'b0; #1;
            chk("rstmid.req", {31'd0, mem_req}, 1);
        end
        @(negedge clk); #2;
        rst = 1'b0; #1;
        chk("rstmid.req0",   {31'd0, mem_req},   0);
        chk("rstmid.stall0", {31'd0, stall_MEM}, 0);
        chk("rstmid.err0",   {31'd0, err_MEM},   0);
        @(negedge clk);
        valid_MEM = 1'b0; memRead_MEM = 1'b0;
        rst = 1'b1;
        halted_m = 1'b0;
        xact("recover", 1'b1, 1'b0, 16'h0042, 16'h0000, 2, 16'h4242, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
